// File: rtl/dmem_pkg.sv
// Shared types for the data-memory arbiter: access sizes, sequencer states and the latched transaction.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_ILL  = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        MERGE  = 2'd2,
        DONE   = 2'd3
    } state_e;

    typedef struct packed {
        logic        owner;
        logic        we;
        size_e       size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
    } txn_t;

    // Misaligned, illegal-size or out-of-range accesses never reach memory.
    function automatic logic access_err(input size_e size, input logic [31:0] addr,
                                        input logic [31:0] limit);
        logic e;
        e = (addr >= limit);
        case (size)
            SZ_HALF: e = e | addr[0];
            SZ_WORD: e = e | (addr[1:0] != 2'b00);
            SZ_ILL:  e = 1'b1;
            default: e = e;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/dmem_lane.sv
// Sub-word lane handling: extract/extend a byte or half from a word, and merge store data into a word.
module dmem_lane
    import dmem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr,
    input  size_e       size,
    input  logic        uns,
    input  logic [31:0] wdata,
    output logic [31:0] ext,
    output logic [31:0] merged
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = word[{addr, 3'b000} +: 8];
        half_v = word[{addr[1], 4'b0000} +: 16];
        case (size)
            SZ_BYTE: ext = {{24{byte_v[7] & ~uns}}, byte_v};
            SZ_HALF: ext = {{16{half_v[15] & ~uns}}, half_v};
            default: ext = word;
        endcase
    end

    always_comb begin
        merged = word;
        case (size)
            SZ_BYTE: merged[{addr, 3'b000} +: 8]      = wdata[7:0];
            SZ_HALF: merged[{addr[1], 4'b0000} +: 16] = wdata[15:0];
            default: merged = wdata;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and load/store sequencer sharing one data-memory port between CPU (p0) and debug (p1).
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [1:0]  p0_size,
    input  logic        p0_uns,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    output logic        p0_gnt,
    output logic        p0_rvalid,
    output logic [31:0] p0_rdata,
    output logic        p0_err,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [1:0]  p1_size,
    input  logic        p1_uns,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p1_gnt,
    output logic        p1_rvalid,
    output logic [31:0] p1_rdata,
    output logic        p1_err,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS * 4);

    state_e      state, next_state;
    txn_t        txn, new_txn;
    logic        last_gnt, sel, accept;
    logic [31:0] old_word, lane_word, lane_ext, lane_merged, resp_data;

    always_comb begin
        sel = (p0_req && p1_req) ? ~last_gnt : p1_req;
        accept = rst_n && (state == IDLE) && (p0_req || p1_req);
        p0_gnt = accept && !sel;
        p1_gnt = accept && sel;

        new_txn       = '0;
        new_txn.owner = sel;
        new_txn.we    = sel ? p1_we    : p0_we;
        new_txn.size  = size_e'(sel ? p1_size : p0_size);
        new_txn.uns   = sel ? p1_uns   : p0_uns;
        new_txn.addr  = sel ? p1_addr  : p0_addr;
        new_txn.wdata = sel ? p1_wdata : p0_wdata;
        new_txn.err   = access_err(new_txn.size, new_txn.addr, MEM_BYTES);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (p0_req || p1_req) next_state = ACCESS;
            ACCESS:  next_state = (!txn.err && txn.we && txn.size != SZ_WORD) ? MERGE : DONE;
            MERGE:   next_state = DONE;
            default: next_state = IDLE;
        endcase
    end

    // Gated by rst_n so a reset landing in MERGE suppresses the write in that same cycle.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (rst_n) begin
            case (state)
                ACCESS: begin
                    mem_addr = {txn.addr[31:2], 2'b00};
                    if (!txn.err && txn.we && txn.size == SZ_WORD) begin
                        mem_we    = 1'b1;
                        mem_wdata = txn.wdata;
                    end
                end
                MERGE: begin
                    mem_addr  = {txn.addr[31:2], 2'b00};
                    mem_we    = 1'b1;
                    mem_wdata = lane_merged;
                end
                default: ;
            endcase
        end
    end

    assign lane_word = (state == MERGE) ? old_word : mem_rdata;

    dmem_lane u_lane (
        .word   (lane_word),
        .addr   (txn.addr[1:0]),
        .size   (txn.size),
        .uns    (txn.uns),
        .wdata  (txn.wdata),
        .ext    (lane_ext),
        .merged (lane_merged)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            txn      <= '0;
            last_gnt <= 1'b1;
            old_word <= '0;
        end else begin
            if (accept) begin
                txn      <= new_txn;
                last_gnt <= sel;
            end
            if (state == ACCESS && next_state == MERGE) old_word <= mem_rdata;
        end
    end

    assign resp_data = (!txn.we && !txn.err) ? lane_ext : '0;

    // Response registers load on the edge entering DONE so rvalid is high exactly during DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p0_rvalid <= 1'b0;
            p0_err    <= 1'b0;
            p0_rdata  <= '0;
            p1_rvalid <= 1'b0;
            p1_err    <= 1'b0;
            p1_rdata  <= '0;
        end else begin
            p0_rvalid <= 1'b0;
            p0_err    <= 1'b0;
            p1_rvalid <= 1'b0;
            p1_err    <= 1'b0;
            if (next_state == DONE) begin
                if (txn.owner) begin
                    p1_rvalid <= 1'b1;
                    p1_err    <= txn.err;
                    p1_rdata  <= resp_data;
                end else begin
                    p0_rvalid <= 1'b1;
                    p0_err    <= txn.err;
                    p0_rdata  <= resp_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed plus randomized bench for dmem_arbiter with a word-array memory and a byte-level reference model.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        p0_req, p0_we, p0_uns, p0_gnt, p0_rvalid, p0_err;
    logic [1:0]  p0_size;
    logic [31:0] p0_addr, p0_wdata, p0_rdata;
    logic        p1_req, p1_we, p1_uns, p1_gnt, p1_rvalid, p1_err;
    logic [1:0]  p1_size;
    logic [31:0] p1_addr, p1_wdata, p1_rdata;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic [31:0] mem [1024];
    logic [31:0] ref_mem [1024];
    logic        mem_clr;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 1024; i++) mem[i] <= '0;
        end else if (mem_we) begin
            mem[mem_addr[11:2]] <= mem_wdata;
        end
    end
    assign mem_rdata = mem[mem_addr[11:2]];

    dmem_arbiter #(.MEM_WORDS(1024)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_size(p0_size), .p0_uns(p0_uns),
        .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid),
        .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_req(p1_req), .p1_we(p1_we), .p1_size(p1_size), .p1_uns(p1_uns),
        .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid),
        .p1_rdata(p1_rdata), .p1_err(p1_err),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input int p, input logic req, input logic we, input logic [1:0] sz,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wd);
        if (p == 0) begin
            p0_req = req; p0_we = we; p0_size = sz; p0_uns = uns; p0_addr = addr; p0_wdata = wd;
        end else begin
            p1_req = req; p1_we = we; p1_size = sz; p1_uns = uns; p1_addr = addr; p1_wdata = wd;
        end
    endtask

    // Reference behaviour computed byte-wise with shifts and masks; updates ref_mem for legal stores.
    task automatic model(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output logic e, output logic [31:0] rd, output int lat,
                         output int nwr, output logic [31:0] new_word);
        logic [31:0] w, mask, v;
        int sh, nbytes;
        e = (sz == 2'd3) || (sz == 2'd1 && addr[0]) || (sz == 2'd2 && addr[1:0] != 0)
            || (addr >= 32'd4096);
        rd = 0; nwr = 0; new_word = 0;
        lat = (!e && we && sz != 2'd2) ? 3 : 2;
        if (e) return;
        w = ref_mem[addr[11:2]];
        nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        sh = (nbytes == 4) ? 0 : 8 * int'(addr[1:0]);
        mask = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 1);
        if (we) begin
            new_word = (w & ~(mask << sh)) | ((wd & mask) << sh);
            ref_mem[addr[11:2]] = new_word;
            nwr = 1;
        end else begin
            v = (w >> sh) & mask;
            if (!uns && nbytes < 4 && v[8 * nbytes - 1]) v = v | ~mask;
            rd = v;
        end
    endtask

    task automatic do_access(input int p, input logic we, input logic [1:0] sz, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wd,
                             output logic [31:0] got_rd, output logic got_err);
        logic e, got, other_rv;
        logic [31:0] rd, new_word;
        int lat, nwr, seen_w, k_done;
        model(we, sz, uns, addr, wd, e, rd, lat, nwr, new_word);
        got_rd = 'x; got_err = 'x;
        @(negedge clk);
        drive(p, 1'b1, we, sz, uns, addr, wd);
        #1;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if ((p == 0) ? p0_gnt : p1_gnt) begin got = 1'b1; break; end
            @(negedge clk); #1;
        end
        chk("gnt_timeout", {31'd0, got}, 32'd1);
        chk("other_gnt", {31'd0, (p == 0) ? p1_gnt : p0_gnt}, 32'd0);
        @(posedge clk); #1;
        drive(p, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
        if (!got) return;
        seen_w = 0; k_done = 0; other_rv = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            other_rv = other_rv | ((p == 0) ? p1_rvalid : p0_rvalid);
            if (mem_we) begin
                seen_w++;
                chk("wr_addr", mem_addr, {addr[31:2], 2'b00});
                chk("wr_data", mem_wdata, new_word);
            end
            if ((p == 0) ? p0_rvalid : p1_rvalid) begin
                k_done = k;
                got_rd = (p == 0) ? p0_rdata : p1_rdata;
                got_err = (p == 0) ? p0_err : p1_err;
                break;
            end
        end
        chk("latency", k_done, lat);
        chk("rdata", got_rd, rd);
        chk("err", {31'd0, got_err}, {31'd0, e});
        chk("writes", seen_w, nwr);
        chk("other_rvalid", {31'd0, other_rv}, 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        logic er;
        int ng, last_c, rv0, rv1, mism;
        logic [1:0] sz;
        logic [31:0] a;

        for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
        rst_n = 1'b0; mem_clr = 1'b1;
        drive(0, 1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        drive(1, 1'b1, 1'b1, 2'd2, 1'b0, 32'h20, 32'h5);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt0", {31'd0, p0_gnt}, 0);
        chk("rst_gnt1", {31'd0, p1_gnt}, 0);
        chk("rst_rvalid", {30'd0, p0_rvalid, p1_rvalid}, 0);
        chk("rst_err", {30'd0, p0_err, p1_err}, 0);
        chk("rst_rdata0", p0_rdata, 0);
        chk("rst_rdata1", p1_rdata, 0);
        chk("rst_mem_we", {31'd0, mem_we}, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        drive(0, 1'b0, 1'b0, 2'd0, 1'b0, 0, 0);
        drive(1, 1'b0, 1'b0, 2'd0, 1'b0, 0, 0);
        rst_n = 1'b1; mem_clr = 1'b0;

        do_access(0, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, rd, er);
        do_access(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, er);
        chk("ld_0x10", rd, 32'hDEADBEEF);

        do_access(1, 1'b1, 2'd2, 1'b0, 32'h20, 32'h11223344, rd, er);
        do_access(1, 1'b1, 2'd0, 1'b0, 32'h21, 32'hAA, rd, er);
        do_access(1, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, rd, er);
        chk("rmw_0x20", rd, 32'h1122AA44);

        do_access(0, 1'b1, 2'd2, 1'b0, 32'h30, 32'h8000F0FF, rd, er);
        do_access(0, 1'b0, 2'd0, 1'b0, 32'h30, 0, rd, er);
        chk("lb_signed", rd, 32'hFFFFFFFF);
        do_access(0, 1'b0, 2'd0, 1'b1, 32'h30, 0, rd, er);
        chk("lbu", rd, 32'h000000FF);
        do_access(1, 1'b0, 2'd1, 1'b0, 32'h32, 0, rd, er);
        chk("lh_signed", rd, 32'hFFFF8000);

        do_access(0, 1'b0, 2'd1, 1'b0, 32'h31, 0, rd, er);
        chk("err_half_mis", {31'd0, er}, 1);
        do_access(1, 1'b1, 2'd2, 1'b0, 32'h42, 32'h12345678, rd, er);
        chk("err_word_mis", {31'd0, er}, 1);
        do_access(0, 1'b0, 2'd2, 1'b0, 32'h1000, 0, rd, er);
        chk("err_range", {31'd0, er}, 1);
        do_access(0, 1'b0, 2'd2, 1'b0, 32'h40, 0, rd, er);
        chk("err_no_write", rd, 32'h0);

        // Reset arriving in the MERGE cycle of a byte store
        do_access(0, 1'b1, 2'd2, 1'b0, 32'h50, 32'hCAFEF00D, rd, er);
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 2'd0, 1'b0, 32'h51, 32'h12);
        #1 chk("rmw_gnt", {31'd0, p0_gnt}, 1);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 2'd0, 1'b0, 0, 0);
        @(negedge clk);
        chk("rmw_read_no_we", {31'd0, mem_we}, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_merge_we", {31'd0, mem_we}, 0);
        chk("rst_merge_addr", mem_addr, 0);
        drive(1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h50, 0);
        @(negedge clk);
        chk("rst_hold_gnt1", {31'd0, p1_gnt}, 0);
        chk("rst_abort_rdata", p0_rdata, 0);
        chk("rst_mem_0x50", mem[20], 32'hCAFEF00D);
        drive(1, 1'b0, 1'b0, 2'd0, 1'b0, 0, 0);
        rst_n = 1'b1;
        rv0 = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rv0 += int'(p0_rvalid) + int'(p1_rvalid);
        end
        chk("rst_no_rvalid", rv0, 0);

        // Continuous requests from both ports right after reset
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 0);
        drive(1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h20, 0);
        ng = 0; last_c = -10; rv0 = 0; rv1 = 0; mism = 0;
        for (int c = 0; c < 30; c++) begin
            #1;
            rv0 += int'(p0_rvalid);
            rv1 += int'(p1_rvalid);
            if (p0_gnt || p1_gnt) begin
                if (p0_gnt && p1_gnt) mism++;
                if (p1_gnt != ng[0]) mism++;
                if (ng > 0 && c - last_c != 3) mism++;
                last_c = c;
                ng++;
            end
            @(negedge clk);
        end
        drive(0, 1'b0, 1'b0, 2'd0, 1'b0, 0, 0);
        drive(1, 1'b0, 1'b0, 2'd0, 1'b0, 0, 0);
        chk("rr_order_gap", mism, 0);
        chk("rr_grants", ng, 10);
        chk("rr_rvalid0", rv0, 5);
        chk("rr_rvalid1", rv1, 5);
        repeat (4) @(negedge clk);

        do_access(0, 1'b0, 2'd2, 1'b0, 32'h50, 0, rd, er);
        chk("rst_abort_mem", rd, 32'hCAFEF00D);

        for (int n = 0; n < 60; n++) begin
            sz = 2'($urandom_range(0, 9) == 0 ? 3 : $urandom_range(0, 2));
            a = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 4) != 0)
                a = a & ~((sz == 2'd1) ? 32'd1 : (sz == 2'd2) ? 32'd3 : 32'd0);
            if ($urandom_range(0, 11) == 0) a = 32'h1000 + a;
            do_access(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), sz,
                      1'($urandom_range(0, 1)), a, $urandom, rd, er);
        end

        mism = 0;
        for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) mism++;
        chk("mem_image", mism, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

endmodule
